// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, immediate
// and mux selects, a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [2:0]  imm_sel,
    output logic        alu_src,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] instret
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic        legal_op;
    logic        is_ld, is_st, is_br, is_jal, is_jalr;

    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[31:15], instr[11:7]};

    always_comb begin
        case (instr[6:0])
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    assign is_ld   = (opcode_q == OP_LOAD);
    assign is_st   = (opcode_q == OP_STORE);
    assign is_br   = (opcode_q == OP_BR);
    assign is_jal  = (opcode_q == OP_JAL);
    assign is_jalr = (opcode_q == OP_JALR);

    always_comb begin
        imm_sel = 3'd0;
        case (opcode_q)
            OP_IMM:          imm_sel = (funct3_q == 3'b001 || funct3_q == 3'b101) ? 3'd5 : 3'd0;
            OP_STORE:        imm_sel = 3'd1;
            OP_BR:           imm_sel = 3'd2;
            OP_LUI, OP_AUIPC: imm_sel = 3'd3;
            OP_JAL:          imm_sel = 3'd4;
            default:         imm_sel = 3'd0;
        endcase
    end

    assign alu_src = !((opcode_q == OP_R) || is_br);
    assign illegal = illegal_q;
    assign instret = instret_q;

    // Strobes depend on same-cycle acks/br_taken and must vanish the instant reset asserts.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        pc_sel   = 2'd0;
        wb_sel   = 2'd0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = legal_op ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    if (is_ld || is_st) begin
                        state_d = S_MEM;
                    end else if (is_br) begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? 2'd1 : 2'd0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_st;
                    if (dmem_ack) begin
                        if (is_st) begin
                            pc_we   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    wb_sel  = is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
                    pc_sel  = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                    state_d = S_FETCH;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= 7'd0;
            funct3_q  <= 3'd0;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= instr[6:0];
                funct3_q <= instr[14:12];
                if (!legal_op) illegal_q <= 1'b1;
            end
            if (pc_we) instret_q <= instret_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-cycle phase model.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, br_taken;
    logic        ir_we, pc_we, reg_we, alu_src, illegal;
    logic [2:0]  imm_sel;
    logic [1:0]  pc_sel, wb_sel;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .br_taken(br_taken), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .imm_sel(imm_sel), .alu_src(alu_src), .pc_sel(pc_sel), .wb_sel(wb_sel),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_cnt  = 32'd0;
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [9:0] ctrl_vec();
        return {imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, pc_sel, wb_sel};
    endfunction

    // Immediate format from the decode table: I=0 S=1 B=2 U=3 J=4 SHAMT=5.
    function automatic logic [2:0] m_imm(input logic [6:0] op, input logic [2:0] f3);
        if (op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) return 3'd5;
        if (op == 7'b0100011) return 3'd1;
        if (op == 7'b1100011) return 3'd2;
        if (op == 7'b0110111 || op == 7'b0010111) return 3'd3;
        if (op == 7'b1101111) return 3'd4;
        return 3'd0;
    endfunction

    // fw: imem wait cycles, dw: dmem wait cycles, rst_at: cycle index at which to pulse reset (-1 none).
    task automatic run_instr(input string nm, input logic [31:0] ins, input int fw, input int dw,
                             input logic brt, input int rst_at);
        logic [6:0] op = ins[6:0];
        logic ld = (op == 7'b0000011), st = (op == 7'b0100011), br = (op == 7'b1100011);
        logic jal = (op == 7'b1101111), jalr = (op == 7'b1100111);
        int   a = fw;
        int   last = br ? a + 2 : st ? a + 3 + dw : ld ? a + 4 + dw : a + 3;
        for (int k = 0; k <= last; k++) begin
            logic in_mem, is_wb, e_pcwe;
            logic [1:0] e_pcsel, e_wbsel;
            @(negedge clk);
            instr    = ins;
            in_mem   = (ld || st) && k >= a + 3 && k <= a + 3 + dw;
            br_taken = (k == a + 2) ? brt : 1'($urandom);
            imem_ack = (k < a) ? 1'b0 : (k == a) ? 1'b1 : 1'($urandom);
            dmem_ack = in_mem ? (k == a + 3 + dw) : 1'($urandom);
            is_wb    = (k == last) && !br && !st;
            e_pcwe   = (k == last);
            e_pcsel  = !e_pcwe ? 2'd0 : br ? {1'b0, brt} : !is_wb ? 2'd0 : jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
            e_wbsel  = !is_wb ? 2'd0 : ld ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0;
            #1;
            chk({nm, "_ctrl"}, ctrl_vec(),
                {k <= a, k == a, in_mem, in_mem && st, e_pcwe, is_wb, e_pcsel, e_wbsel});
            if (k == a + 2) begin
                chk({nm, "_imm_sel"}, imm_sel, m_imm(op, ins[14:12]));
                chk({nm, "_alu_src"}, alu_src, !(op == 7'b0110011 || br));
            end
            if (k == rst_at) begin
                rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
                #1;
                chk({nm, "_rst_ctrl"}, ctrl_vec(), 10'd0);
                chk({nm, "_rst_instret"}, instret, 32'd0);
                m_cnt = 32'd0;
                @(negedge clk);
                rst_n = 1'b1;
                #1 chk({nm, "_rst_fetch"}, imem_req, 1'b1);
                return;
            end
        end
        m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1 chk({nm, "_instret"}, instret, m_cnt);
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'd0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
        #1;
        chk("reset_ctrl", ctrl_vec(), 10'd0);
        chk("reset_illegal", illegal, 1'b0);
        chk("reset_instret", instret, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("first_fetch", imem_req, 1'b1);

        run_instr("addi",  32'h00500093, 0, 0, 1'b0, -1);
        run_instr("lw",    32'h0000a103, 0, 3, 1'b0, -1);
        run_instr("beq_t", 32'h00000063, 0, 0, 1'b1, -1);
        run_instr("beq_n", 32'h00000063, 1, 0, 1'b0, -1);
        run_instr("slli",  32'h00109093, 0, 0, 1'b0, -1);
        run_instr("jalr",  32'h000080e7, 0, 0, 1'b0, -1);
        run_instr("sw",    32'h0020a023, 2, 1, 1'b0, -1);
        run_instr("lui",   32'h123450b7, 0, 0, 1'b0, -1);
        run_instr("auipc", 32'h00001097, 0, 0, 1'b0, -1);
        run_instr("jal",   32'h0000006f, 0, 0, 1'b0, -1);
        run_instr("add",   32'h002081b3, 0, 0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] r = $urandom;
            r[6:0] = ops[$urandom_range(8)];
            run_instr("rnd", r, int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom), -1);
        end

        run_instr("lw_rst", 32'h0000a103, 1, 5, 1'b0, 5);
        run_instr("post_rst", 32'h00500093, 0, 0, 1'b0, -1);

        dut.instret_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        run_instr("wrap", 32'h00500093, 0, 0, 1'b0, -1);

        // Illegal opcode: fetch, decode, then absorbing trap ignoring imem_ack.
        @(negedge clk); instr = 32'h00000000; imem_ack = 1'b1; dmem_ack = 1'b0;
        #1 chk("ill_fetch", ctrl_vec(), {1'b1, 1'b1, 8'd0});
        @(negedge clk); imem_ack = 1'b0;
        #1 chk("ill_decode_flag", illegal, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            #1;
            chk("trap_ctrl", ctrl_vec(), 10'd0);
            chk("trap_illegal", illegal, 1'b1);
        end
        chk("trap_instret", instret, m_cnt);
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("trap_rst_illegal", illegal, 1'b0);
        chk("trap_rst_ctrl", ctrl_vec(), 10'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("trap_restart", imem_req, 1'b1);
        m_cnt = 32'd0;
        run_instr("after_trap", 32'h00500093, 0, 0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL provide: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL provide: rst_n  in  1  asynchronous active-low reset.
REQ-003 The block SHALL provide: instr  in  32  instruction register contents (opcode = instr[6:0], funct3 = instr[14:12]).
REQ-004 The block SHALL provide: imem_req  out  1  instruction fetch request.
REQ-005 The block SHALL provide: imem_ack  in  1  fetch data valid this cycle.
REQ-006 The block SHALL provide: dmem_req  out  1  data memory request.
REQ-007 The block SHALL provide: dmem_we  out  1  data memory write (store).
REQ-008 The block SHALL provide: dmem_ack  in  1  data access complete this cycle.
REQ-009 The block SHALL provide: br_taken  in  1  branch comparison result from ALU.
REQ-010 The block SHALL provide: ir_we, pc_we, reg_we  out  1 each  instruction register, PC and register-file write enables.
REQ-011 The block SHALL provide: imm_sel  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT (5-bit, zero-extended).
REQ-012 The block SHALL provide: alu_src  out  1  0 = rs2, 1 = immediate.
REQ-013 The block SHALL provide: pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = rs1+imm (JALR).
REQ-014 The block SHALL provide: wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4.
REQ-015 The block SHALL provide: illegal  out  1  sticky illegal-opcode flag.
REQ-016 The block SHALL provide: instret  out  32  retired-instruction count.

Function
REQ-017 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-018 FETCH SHALL hold imem_req=1 until imem_ack, then pulse ir_we=1 for that cycle and go to DECODE.
REQ-019 DECODE SHALL last one cycle, register opcode/funct3 from instr, and go to EXEC, or to TRAP if the opcode is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111.
REQ-020 imm_sel SHALL be driven from the registered opcode as follows: LOAD/JALR/I-ALU = I; I-ALU with funct3 001 or 101 = SHAMT; STORE = S; BRANCH = B; LUI/AUIPC = U; JAL = J; R-type = 0.
REQ-021 alu_src SHALL be 1 for every opcode except R-type and BRANCH.
REQ-022 From EXEC: LOAD/STORE SHALL go to MEM; BRANCH SHALL go to FETCH with pc_we=1 and pc_sel=1 if br_taken else 0; all other opcodes SHALL go to WB.
REQ-023 MEM SHALL hold dmem_req=1 (dmem_we=1 for STORE) until dmem_ack.
REQ-024 On dmem_ack in MEM, LOAD SHALL go to WB and STORE SHALL go to FETCH with pc_we=1, pc_sel=0.
REQ-025 WB SHALL last one cycle with reg_we=1 and pc_we=1, then go to FETCH.
REQ-026 In WB, wb_sel SHALL be 1 for LOAD, 2 for JAL/JALR, and 0 otherwise.
REQ-027 In WB, pc_sel SHALL be 1 for JAL, 2 for JALR, and 0 otherwise.
REQ-028 reg_we, pc_we, ir_we, dmem_req and dmem_we SHALL be 0 in every state/cycle not listed in REQ-018 to REQ-027.
REQ-029 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-030 A retirement SHALL be any cycle with pc_we=1; instret SHALL increment by 1 on each retirement and wrap from 0xFFFFFFFF to 0.
REQ-031 Minimum latency SHALL be 4 cycles for R/I/LUI/AUIPC/JAL/JALR, 3 cycles for BRANCH, 4 cycles for STORE, and 5 cycles for LOAD, each with zero-wait acks.
REQ-032 TRAP SHALL be absorbing, with illegal=1 and all enables 0, until reset.

Reset
REQ-033 Assertion of rst_n=0 SHALL take effect immediately, in any state including mid-MEM, and SHALL force state=FETCH, illegal=0, instret=0, and opcode/funct3 registers to 0.
REQ-034 While in reset, all enables and request outputs SHALL be 0.
REQ-035 The first imem_req SHALL assert in the first cycle after rst_n deasserts.

Verification
REQ-036 The bench SHALL cover: ADDI (0x00500093) with imem_ack on the first cycle -> ir_we, then EXEC with alu_src=1, imm_sel=0, then WB with reg_we=1, pc_we=1, wb_sel=0; instret=1 after 4 cycles.
REQ-037 The bench SHALL cover: LW with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, WB wb_sel=1; total 8 cycles; instret increments once.
REQ-038 The bench SHALL cover: BEQ with br_taken=1, then with br_taken=0 -> pc_we in EXEC with pc_sel=1, then pc_sel=0, reg_we never asserted, imm_sel=2.
REQ-039 The bench SHALL cover: SLLI (funct3 001) -> imm_sel=5; JALR -> WB pc_sel=2, wb_sel=2.
REQ-040 The bench SHALL cover: opcode 0000000 -> illegal=1 from the cycle after DECODE, no further imem_req, and imem_ack pulses ignored; rst_n low then clears illegal and restarts FETCH.
REQ-041 The bench SHALL cover: rst_n asserted mid-MEM with dmem_req=1 -> dmem_req drops immediately and instret=0; also preload instret=0xFFFFFFFF, retire one instruction -> instret=0.
